inv_pl: RTL and testbench
=========================

INV_PL -- requirements
Module: inv_pl

Interface
REQ-001 The parameter list SHALL be: UNROLL, default 1, number of inverse steps applied per clock cycle; legal values 1, 2, 3, 6.
REQ-002 Port clock_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_i, input, 1 bit; reset SHALL be asynchronous and active-high.
REQ-004 Port start_i, input, 1 bit, request to invert state_i; sampled only when the block is not busy.
REQ-005 Port state_i, input, type_state (5 x 64 bit), the diffused state to invert.
REQ-006 Port state_o, output, type_state, the inverse-linear-layer result; held stable outside RUN.
REQ-007 Port busy_o, output, 1 bit, high while the block is computing.
REQ-008 Port done_o, output, 1 bit, single-cycle pulse marking state_o valid.

Function
REQ-009 The block SHALL compute the inverse of the Ascon linear diffusion layer, word-wise, with right rotations (ROTR) on 64-bit words.
REQ-010 The per-word rotation pairs (a,b) SHALL be: word0 (19,28), word1 (61,39), word2 (1,6), word3 (10,17), word4 (7,41).
REQ-011 The inverse SHALL be computed as six sequential steps k = 0..5, each applying x <= x ^ ROTR(x, (a*2^k) mod 64) ^ ROTR(x, (b*2^k) mod 64) to every word. This realises Sigma^63 = Sigma^-1, because Sigma^64 is the identity.
REQ-012 Step order SHALL be k ascending; all five words SHALL advance in the same cycle.
REQ-013 The FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE, with start_i = 1: the block SHALL load state_i into the working register, clear the step counter and go to RUN; with start_i = 0 it SHALL stay in IDLE.
REQ-015 In RUN, each cycle SHALL apply UNROLL consecutive steps and advance the step counter by UNROLL.
REQ-016 RUN SHALL go to DONE on the cycle in which the counter reaches 6.
REQ-017 DONE SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-018 In DONE, start_i = 1 SHALL be accepted as in IDLE (back-to-back operation), going directly to RUN.
REQ-019 Latency from the start_i sampling edge to done_o high SHALL be 6/UNROLL + 1 cycles.
REQ-020 busy_o SHALL be high exactly in RUN; start_i SHALL be ignored while busy_o = 1 and state_i SHALL not be re-sampled.
REQ-021 state_o SHALL be driven from the working register; its value is defined as valid only from done_o high until the next accepted start.
REQ-022 The step counter SHALL be 3 bits and SHALL never exceed 6; a counter value outside the legal sequence SHALL force the FSM back to IDLE.
REQ-023 A UNROLL value outside {1,2,3,6} SHALL cause an elaboration-time error.

Reset
REQ-024 While reset_i = 1, the FSM SHALL be IDLE, the step counter 0, the working register and state_o all-zero, and busy_o = done_o = 0, independent of clock_i.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done_o pulse; the first start_i after release SHALL begin a fresh computation.

Structure
REQ-026 type_state and a new constant table of the five (a,b) rotation pairs SHALL live in ascon_pack; the FSM state enum SHALL be local to the module.
REQ-027 One sub-module inv_pl_step SHALL exist: a combinational single step with input parameter K (0..5), built on the existing parameterised rotation module.
REQ-028 inv_pl SHALL instantiate inv_pl_step for k = 0..5 and select per cycle by counter; for UNROLL > 1 it SHALL chain UNROLL instances.

Verification
REQ-029 Zero: state_i all-zero, start -> done_o after 7 cycles (UNROLL = 1), state_o all-zero.
REQ-030 All-ones: every word 0xFFFFFFFFFFFFFFFF -> state_o all words 0xFFFFFFFFFFFFFFFF.
REQ-031 Round trip: state_i word0 = 0x80400C0600000000, words 1-4 random -> pl(state_o) equals state_i; also pl then inv_pl returns the input, 1000 random vectors, for every UNROLL value.
REQ-032 Handshake: start_i held high for 20 cycles -> exactly one done_o per 7 cycles, busy_o low only in DONE/IDLE cycles, and state_i changes during RUN have no effect.
REQ-033 Reset mid-op: reset_i pulsed at RUN cycle 3 -> state_o = 0, no done_o pulse; the next start yields the correct result.
REQ-034 Latency sweep: UNROLL = 1, 2, 3, 6 -> done_o at cycles 7, 4, 3, 2 respectively, with identical results.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared Ascon types and the linear-layer rotation table used by the
// inverse linear layer.
package ascon_pack;

  localparam int N_WORDS = 5;
  localparam int N_STEPS = 6;

  typedef logic [63:0] type_word;
  typedef type_word [N_WORDS-1:0] type_state;

  typedef struct packed {
    logic [5:0] a;
    logic [5:0] b;
  } type_rot_pair;

  localparam type_rot_pair [N_WORDS-1:0] ROT_PAIRS = '{
    0: '{a: 6'd19, b: 6'd28},
    1: '{a: 6'd61, b: 6'd39},
    2: '{a: 6'd1,  b: 6'd6},
    3: '{a: 6'd10, b: 6'd17},
    4: '{a: 6'd7,  b: 6'd41}
  };

  // Rotation amount of step k: the base amount doubled k times, modulo the word size.
  function automatic int unsigned step_rot(input int unsigned amt, input int unsigned k);
    return (amt << k) % 64;
  endfunction

endpackage

// File: rtl/ascon_rotr.sv
// Parameterised constant right rotation of a 64-bit word.
module ascon_rotr #(
  parameter int unsigned SHIFT = 0
) (
  input  logic [63:0] x_i,
  output logic [63:0] y_o
);

  if (SHIFT == 0) begin : g_pass
    assign y_o = x_i;
  end else begin : g_rot
    assign y_o = {x_i[SHIFT-1:0], x_i[63:SHIFT]};
  end

endmodule

// File: rtl/inv_pl_step.sv
// One combinational step k of the inverse linear layer:
// x ^ ROTR(x, a*2^k) ^ ROTR(x, b*2^k) on every word.
module inv_pl_step
  import ascon_pack::*;
#(
  parameter int unsigned K = 0
) (
  input  type_state x_i,
  output type_state y_o
);

  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    localparam int unsigned RA = step_rot(32'(ROT_PAIRS[w].a), K);
    localparam int unsigned RB = step_rot(32'(ROT_PAIRS[w].b), K);

    logic [63:0] rot_a;
    logic [63:0] rot_b;

    ascon_rotr #(.SHIFT(RA)) u_rot_a (.x_i(x_i[w]), .y_o(rot_a));
    ascon_rotr #(.SHIFT(RB)) u_rot_b (.x_i(x_i[w]), .y_o(rot_b));

    assign y_o[w] = x_i[w] ^ rot_a ^ rot_b;
  end

endmodule

// File: rtl/inv_pl.sv
// Iterative inverse of the Ascon linear diffusion layer: six doubling steps
// (Sigma^63 = Sigma^-1), UNROLL steps per clock.
module inv_pl
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  type_state state_i,
  output type_state state_o,
  output logic      busy_o,
  output logic      done_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("inv_pl: UNROLL must be 1, 2, 3 or 6");
  end

  localparam int         N_GRP = N_STEPS / UNROLL;
  localparam logic [2:0] U3    = 3'(UNROLL);
  localparam logic [2:0] LAST  = 3'(N_STEPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e    fsm_q, fsm_d;
  logic [2:0] cnt_q, cnt_d;
  type_state work_q, work_d;

  logic [2:0] grp;
  logic       cnt_legal;
  type_state  step_out;

  assign grp       = cnt_q / U3;
  assign cnt_legal = (cnt_q < LAST) && ((cnt_q % U3) == 3'd0);

  // Chain position j only ever executes steps k = j, j+UNROLL, ...; the
  // counter picks which of those is active this cycle.
  for (genvar j = 0; j < UNROLL; j++) begin : g_pos
    type_state x_in;
    type_state y_out;
    type_state cand [N_GRP];

    if (j == 0) begin : g_head
      assign x_in = work_q;
    end else begin : g_link
      assign x_in = g_pos[j-1].y_out;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      inv_pl_step #(.K(g * UNROLL + j)) u_step (.x_i(x_in), .y_o(cand[g]));
    end

    always_comb begin
      y_out = cand[0];
      for (int g = 1; g < N_GRP; g++) begin
        if (grp == 3'(g)) y_out = cand[g];
      end
    end
  end

  assign step_out = g_pos[UNROLL-1].y_out;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    work_d = work_q;
    busy_o = 1'b0;
    done_o = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          work_d = state_i;
          cnt_d  = 3'd0;
          fsm_d  = S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (cnt_legal) begin
          work_d = step_out;
          cnt_d  = cnt_q + U3;
          if (cnt_d == LAST) fsm_d = S_DONE;
        end else begin
          cnt_d = 3'd0;
          fsm_d = S_IDLE;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          work_d = state_i;
          cnt_d  = 3'd0;
          fsm_d  = S_RUN;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        cnt_d = 3'd0;
        fsm_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only; the working
  // register is ordinary flops and is cleared by reset like the control state.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= 3'd0;
      work_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      work_q <= work_d;
    end
  end

  assign state_o = work_q;

endmodule

// File: tb/tb_inv_pl.sv
// Bench for inv_pl: four instances (UNROLL 1,2,3,6) checked every cycle
// against a Sigma^63 reference model, plus directed literal expectations.
module tb_inv_pl;

  typedef logic [4:0][63:0] st_t;

  localparam int NDUT = 4;
  localparam int U_TAB   [NDUT] = '{1, 2, 3, 6};
  localparam int LAT_EXP [NDUT] = '{7, 4, 3, 2};
  localparam int HS_EXP  [NDUT] = '{3, 5, 7, 10};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic clk = 1'b0;
  logic rst;
  logic start;
  st_t  state_in;

  st_t  st_o   [NDUT];
  logic busy_w [NDUT];
  logic done_w [NDUT];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NDUT; i++) begin : g_dut
    inv_pl #(.UNROLL(U_TAB[i])) u_dut (
      .clock_i(clk),
      .reset_i(rst),
      .start_i(start),
      .state_i(state_in),
      .state_o(st_o[i]),
      .busy_o (busy_w[i]),
      .done_o (done_w[i])
    );
  end

  task automatic check(input string name, input int u, input logic [319:0] act,
                       input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (u=%0d) actual=%h expected=%h", name, u, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t sigma_fwd(input st_t s);
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = s[w] ^ rotr(s[w], RA[w]) ^ rotr(s[w], RB[w]);
    return r;
  endfunction

  // Sigma^64 is the identity, so 63 forward applications give the inverse.
  function automatic st_t inv_model(input st_t s);
    st_t r = s;
    for (int n = 0; n < 63; n++) r = sigma_fwd(r);
    return r;
  endfunction

  // Reference: an accepted start yields inv(input) with done after 6/U edges;
  // the block is busy in between and can accept again in the done cycle.
  int   rem      [NDUT] = '{default: 0};
  logic exp_done [NDUT] = '{default: 1'b0};
  st_t  exp_st   [NDUT] = '{default: '0};
  st_t  pend_st  [NDUT] = '{default: '0};
  st_t  acc_in   [NDUT] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        rem[i] = 0;
        exp_done[i] = 1'b0;
        exp_st[i] = '0;
      end else if (rem[i] > 0) begin
        rem[i]--;
        exp_done[i] = (rem[i] == 0);
        if (rem[i] == 0) exp_st[i] = pend_st[i];
      end else begin
        exp_done[i] = 1'b0;
        if (start) begin
          rem[i] = 6 / U_TAB[i];
          acc_in[i] = state_in;
          pend_st[i] = inv_model(state_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      check("busy", U_TAB[i], 320'(busy_w[i]), 320'(rem[i] > 0));
      check("done", U_TAB[i], 320'(done_w[i]), 320'(exp_done[i]));
      if (rem[i] == 0) check("state", U_TAB[i], st_o[i], exp_st[i]);
      if (exp_done[i]) check("roundtrip", U_TAB[i], sigma_fwd(st_o[i]), acc_in[i]);
    end
  end

  function automatic st_t rand_state();
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom(), $urandom()};
    return r;
  endfunction

  task automatic run_op(input st_t v);
    int  lat [NDUT];
    bit  all_seen;
    for (int i = 0; i < NDUT; i++) lat[i] = 0;
    @(negedge clk);
    #1 start = 1'b1;
    state_in = v;
    all_seen = 1'b0;
    for (int n = 1; n <= 20 && !all_seen; n++) begin
      @(negedge clk);
      all_seen = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
        if (done_w[i] && lat[i] == 0) lat[i] = n;
        if (lat[i] == 0) all_seen = 1'b0;
      end
      #1 start = 1'b0;
    end
    for (int i = 0; i < NDUT; i++) check("latency", U_TAB[i], 320'(lat[i]), 320'(LAT_EXP[i]));
  endtask

  int dcount [NDUT];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    state_in = '0;

    // Pin the reference model with hand-computed values.
    begin
      st_t a, ones, rt;
      a = '0;
      a[2] = 64'h1;
      check("model_fwd_bit", 0, sigma_fwd(a), {64'h0, 64'h0, 64'h8400000000000001, 64'h0, 64'h0});
      ones = '1;
      check("model_inv_ones", 0, inv_model(ones), {5{64'hFFFFFFFFFFFFFFFF}});
      rt = '0;
      rt[0] = 64'h80400C0600000000;
      check("model_inv_fwd", 0, sigma_fwd(inv_model(rt)), {256'h0, 64'h80400C0600000000});
    end

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("reset_state", U_TAB[i], st_o[i], '0);

    run_op('0);
    for (int i = 0; i < NDUT; i++) check("zero_result", U_TAB[i], st_o[i], '0);

    run_op('1);
    for (int i = 0; i < NDUT; i++)
      check("ones_result", U_TAB[i], st_o[i], {5{64'hFFFFFFFFFFFFFFFF}});

    begin
      st_t v;
      v = rand_state();
      v[0] = 64'h80400C0600000000;
      run_op(v);
      for (int i = 0; i < NDUT; i++) check("vec_roundtrip", U_TAB[i], sigma_fwd(st_o[i]), v);
    end

    for (int n = 0; n < 1000; n++) run_op(rand_state());

    // start held high for 20 edges while state_i keeps changing
    for (int i = 0; i < NDUT; i++) dcount[i] = 0;
    @(negedge clk);
    #1 start = 1'b1;
    state_in = rand_state();
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) if (done_w[i]) dcount[i]++;
      #1 state_in = rand_state();
      if (n == 19) start = 1'b0;
    end
    for (int i = 0; i < NDUT; i++) check("handshake_dones", U_TAB[i], 320'(dcount[i]), 320'(HS_EXP[i]));

    // reset pulse in the third RUN cycle of the UNROLL=1 instance
    for (int i = 0; i < NDUT; i++) dcount[i] = 0;
    @(negedge clk);
    #1 start = 1'b1;
    state_in = rand_state();
    @(negedge clk);
    #1 start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done_w[0]) dcount[0]++;
    end
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("async_rst_state", U_TAB[i], st_o[i], '0);
      check("async_rst_busy", U_TAB[i], 320'(busy_w[i]), 320'(0));
      check("async_rst_done", U_TAB[i], 320'(done_w[i]), 320'(0));
    end
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done_w[0]) dcount[0]++;
    end
    check("abort_no_done", 1, 320'(dcount[0]), 320'(0));

    begin
      st_t v;
      v = rand_state();
      run_op(v);
      for (int i = 0; i < NDUT; i++) check("after_reset", U_TAB[i], sigma_fwd(st_o[i]), v);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
